// File: rtl/inst_fetch_cache_if.sv
// Fetch-side and memory-side bus of inst_fetch_cache.
// ICACHE_STATS_EN adds the hit_count/miss_count outputs.
interface inst_fetch_cache_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] P_reg;
   logic [ADDR_W-1:0] mem_offset;
   logic              paging;
   logic              fetch_req;
   logic [DATA_W-1:0] instruction;
   logic              inst_valid;
   logic              flush;
   logic              busy;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_data;
`ifdef ICACHE_STATS_EN
   logic [15:0]       hit_count;
   logic [15:0]       miss_count;
`endif

   modport slave (
      input  P_reg, mem_offset, paging, fetch_req, flush, mem_ack, mem_data,
      output instruction, inst_valid, busy, mem_req, mem_addr
`ifdef ICACHE_STATS_EN
      , output hit_count, miss_count
`endif
   );

   modport master (
      output P_reg, mem_offset, paging, fetch_req, flush, mem_ack, mem_data,
      input  instruction, inst_valid, busy, mem_req, mem_addr
`ifdef ICACHE_STATS_EN
      , input hit_count, miss_count
`endif
   );
endinterface

// File: rtl/inst_fetch_cache.sv
// Direct-mapped instruction cache with line refill over a req/ack memory port.
// Optional ICACHE_STATS_EN: saturating hit/miss lookup counters.
module inst_fetch_cache #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int LINES      = 16,
   parameter int LINE_WORDS = 4
) (
   input logic               clock,
   input logic               reset,
   inst_fetch_cache_if.slave bus
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

   localparam logic [1:0] ST_FLUSH = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_FILL  = 2'd2;

   logic [1:0]              state;
   logic [IDX_W-1:0]        line_cnt;
   logic [OFF_W-1:0]        word_cnt;
   logic [ADDR_W-OFF_W-1:0] base_line;
   logic                    flush_pend;
   logic [LINES-1:0]        valid;
   logic [TAG_W-1:0]        tag_mem  [LINES];
   logic [DATA_W-1:0]       data_mem [LINES*LINE_WORDS];

   logic [DATA_W-1:0]       instruction_q;
   logic                    inst_valid_q;
   logic                    mem_req_q;
   logic [ADDR_W-1:0]       mem_addr_q;

   logic [ADDR_W-1:0]       fetch_addr;
   logic [OFF_W-1:0]        fa_off;
   logic [IDX_W-1:0]        fa_idx;
   logic [TAG_W-1:0]        fa_tag;
   logic [IDX_W-1:0]        fill_idx;
   logic [TAG_W-1:0]        fill_tag;
   logic                    lookup;
   logic                    hit;
   logic                    fill_we;
   logic                    fill_last;

   always_comb begin
      fetch_addr = bus.paging ? bus.P_reg + bus.mem_offset : bus.P_reg;
      {fa_tag, fa_idx, fa_off} = fetch_addr;
      fill_idx  = base_line[IDX_W-1:0];
      fill_tag  = base_line[IDX_W +: TAG_W];
      // a flush in the same cycle as a request pre-empts the lookup
      lookup    = (state == ST_IDLE) && !bus.flush && bus.fetch_req && !inst_valid_q;
      hit       = valid[fa_idx] && (tag_mem[fa_idx] == fa_tag);
      fill_we   = (state == ST_FILL) && bus.mem_ack;
      fill_last = fill_we && (word_cnt == OFF_W'(LINE_WORDS - 1));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= ST_FLUSH;
         line_cnt      <= '0;
         word_cnt      <= '0;
         base_line     <= '0;
         flush_pend    <= 1'b0;
         valid         <= '0;
         instruction_q <= '0;
         inst_valid_q  <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
      end else begin
         inst_valid_q <= 1'b0;
         case (state)
            ST_FLUSH: begin
               valid[line_cnt] <= 1'b0;
               if (bus.flush)
                  line_cnt <= '0;
               else if (line_cnt == IDX_W'(LINES - 1))
                  state <= ST_IDLE;
               else
                  line_cnt <= line_cnt + IDX_W'(1);
            end
            ST_IDLE: begin
               if (bus.flush) begin
                  state    <= ST_FLUSH;
                  line_cnt <= '0;
               end else if (lookup) begin
                  if (hit) begin
                     instruction_q <= data_mem[{fa_idx, fa_off}];
                     inst_valid_q  <= 1'b1;
                  end else begin
                     state      <= ST_FILL;
                     base_line  <= fetch_addr[ADDR_W-1:OFF_W];
                     word_cnt   <= '0;
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= {fetch_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  end
               end
            end
            ST_FILL: begin
               if (bus.flush)
                  flush_pend <= 1'b1;
               if (fill_we) begin
                  word_cnt <= word_cnt + OFF_W'(1);
                  if (fill_last) begin
                     // line completes first; a pending flush then invalidates it
                     valid[fill_idx] <= 1'b1;
                     mem_req_q       <= 1'b0;
                     flush_pend      <= 1'b0;
                     line_cnt        <= '0;
                     state           <= (flush_pend || bus.flush) ? ST_FLUSH : ST_IDLE;
                  end else begin
                     mem_addr_q <= {base_line, word_cnt + OFF_W'(1)};
                  end
               end
            end
            default: state <= ST_FLUSH;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (fill_we)
         data_mem[{fill_idx, word_cnt}] <= bus.mem_data;
      if (fill_last)
         tag_mem[fill_idx] <= fill_tag;
   end

   assign bus.instruction = instruction_q;
   assign bus.inst_valid  = inst_valid_q;
   assign bus.busy        = (state != ST_IDLE);
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = mem_addr_q;

`ifdef ICACHE_STATS_EN
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (lookup) begin
         if (hit) begin
            if (hit_cnt != '1)
               hit_cnt <= hit_cnt + 16'd1;
         end else begin
            if (miss_cnt != '1)
               miss_cnt <= miss_cnt + 16'd1;
         end
      end
   end

   assign bus.hit_count  = hit_cnt;
   assign bus.miss_count = miss_cnt;
`endif
endmodule

// File: doc/inst_fetch_cache.md
Name: inst_fetch_cache

Overview:
Parametrised direct-mapped instruction cache between the CPU fetch stage and the memory controller. It translates the program counter, with an optional page offset, into a fetch address and returns the instruction word from the cache. On a miss it refills a whole line from memory using a request/acknowledge handshake. It also supports a multi-cycle invalidate (flush).

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 16, word address width
LINES, 16, number of cache lines (power of 2, >=2)
LINE_WORDS, 4, words per line (power of 2, >=2)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
P_reg  in  ADDR_W  program counter (word address)
mem_offset  in  ADDR_W  page base added when paging=1
paging  in  1  1: fetch address = P_reg + mem_offset (mod 2^ADDR_W); 0: P_reg
fetch_req  in  1  level request; held by CPU until inst_valid
instruction  out  DATA_W  fetched word, registered
inst_valid  out  1  one-cycle strobe, instruction valid
flush  in  1  one-cycle pulse, invalidate all lines
busy  out  1  high in FLUSH or FILL
mem_req  out  1  line-fill word request
mem_addr  out  ADDR_W  word address for mem_req
mem_ack  in  1  memory returns mem_data this cycle
mem_data  in  DATA_W  fill data

Behaviour:
- Address split, from LSB: offset = log2(LINE_WORDS) bits; index = log2(LINES) bits; tag = remaining bits.
- Storage: data array LINES*LINE_WORDS x DATA_W, tag array, valid bit per line.
- Reset values: instruction=0, inst_valid=0, mem_req=0, mem_addr=0, busy=1. State=FLUSH, line counter=0.
- FLUSH: clears one valid bit per cycle, taking LINES cycles, then goes to IDLE. fetch_req is ignored.
- IDLE: busy=0. When fetch_req=1 and inst_valid=0, look up the fetch address.
  - Hit: on the next edge, instruction=data and inst_valid=1 for exactly one cycle. Hit latency is 1 cycle.
  - Miss: go to FILL. Latch line base = fetch address with offset bits zeroed. Word counter=0.
- After a delivered strobe, the CPU either drops fetch_req or presents a new P_reg. Back-to-back requests therefore yield a strobe every second cycle at most.
- FILL: mem_req=1. mem_addr = base + counter, held stable until mem_ack.
  - Each mem_ack writes mem_data into the line and increments the counter.
  - On the ack of the last word: write the tag, set valid, go to IDLE.
  - The held fetch_req then hits. Miss latency = LINE_WORDS acks + 2 cycles.
  - mem_req falls on the edge after the final ack.
- flush:
  - In IDLE: go to FLUSH. If fetch_req is simultaneous, no lookup occurs.
  - In FILL: latched as pending. The fill completes and the line is marked valid, then FLUSH runs.
  - In FLUSH: restarts the counter at 0.
- Fetch address wraps modulo 2^ADDR_W. Line base arithmetic also wraps, so a line never straddles 0.
- P_reg/paging changing during FILL does not alter the fill. The lookup after FILL uses the current address (may miss again).
- Reset mid-FILL: mem_req drops asynchronously, partial line discarded, FLUSH re-runs.
- A mem_ack outside FILL is ignored.

Optional Feature:
ICACHE_STATS_EN:
- When defined, adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments once per lookup in IDLE that resolves as hit or miss.
  - Both saturate at 16'hFFFF, clear on reset, and are unaffected by flush.
- When undefined, the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then hold 20 cycles -> busy=1 for exactly 16 cycles then 0; mem_req=0 throughout.
- paging=0, P_reg=16'h0012, fetch_req, memory acks every cycle with data=addr^16'hA5A5 -> mem_addr 0010,0011,0012,0013; inst_valid 2 cycles after last ack; instruction=16'hA5B7.
- After previous fill, P_reg=16'h0011 -> inst_valid next cycle with 16'hA5B4, no mem_req.
- paging=1, mem_offset=16'hFFFE, P_reg=16'h0003 -> fetch address 16'h0001, fill of 0000..0003.
- flush pulse mid-FILL (after 2 acks) -> fill completes with 4 acks, then busy held 16 more cycles; same P_reg then misses again.
- Assert reset during FILL with mem_req=1 -> mem_req=0 with no clock edge; later fetch of the same address refills.
